rx_poll_scheduler: RTL and testbench
====================================

// Module: rx_poll_scheduler
// PURPOSE
//  Round-robin poll sequencer for NCH receive channels sharing one request/response protocol.
//  On each frame_tick it walks channels 0..NCH-1 in order:
//    - issues a fixed-length req pulse to the channel;
//    - waits for that channel's rx_done rising edge, bounded by a timeout;
//    - moves to the next channel.
//  Sits between the frame timer and the per-channel receivers; reports per-round timeouts.
// PARAMETERS
//  NCH      4   number of polled channels (>=2)
//  REQ_LEN  5   req high time per channel, clk cycles (>=1)
//  TIMEOUT  16  max WAIT cycles for rx_done edge before the channel is declared silent (>=2)
// PORTS
//  clk            in   1        system clock, all logic on posedge
//  nRST           in   1        synchronous reset, active-low
//  en             in   1        scheduler enable; low forces IDLE
//  frame_tick     in   1        1-cycle pulse: start a poll round
//  rx_done        in   NCH      per-channel receive-complete level from receivers
//  req            out  NCH      one-hot request pulse to current channel (registered)
//  cur_ch         out  clog2(NCH) channel currently being served
//  busy           out  1        high while a round is in progress
//  round_done     out  1        1-cycle pulse when the last channel finishes
//  timeout_flags  out  NCH      bit i set if channel i timed out in the current/last round
//  overrun        out  1        1-cycle pulse: frame_tick arrived while busy (tick ignored)
// BEHAVIOUR
//  Reset (nRST=0 at posedge): all outputs 0, state IDLE, ch=0, counters 0, edge regs 0.
//  Edge detect: rx_d <= rx_done each cycle; rise[i] = rx_done[i] & ~rx_d[i].
//  FSM states:
//   IDLE: busy=0, req=0. en & frame_tick -> REQ with ch=0, cnt=0, timeout_flags cleared.
//   REQ:  req[ch]=1 for exactly REQ_LEN cycles. First high cycle is the cycle after the accepted tick.
//         rise[ch] during REQ latches got=1. After REQ_LEN cycles -> WAIT, cnt=0.
//   WAIT: req=0.
//         got | rise[ch] -> NEXT.
//         Else if cnt==TIMEOUT-1 -> set timeout_flags[ch], NEXT.
//         Else cnt++.
//   NEXT: one cycle, got cleared.
//         ch==NCH-1 -> round_done=1, IDLE (ch stays NCH-1 until next round).
//         Otherwise ch++, cnt=0, REQ.
//  Per-channel cost: REQ_LEN + (wait cycles, <=TIMEOUT) + 1 (NEXT).
//  Worst round = NCH*(REQ_LEN+TIMEOUT+1) cycles.
//  busy=1 in REQ, WAIT, NEXT. cur_ch = ch.
//  Only one req bit is ever high. rise on non-current channels is ignored.
//  frame_tick while busy -> overrun pulse next cycle; round continues unaffected.
//  frame_tick with en=0 ignored, no overrun.
//  en falls mid-round -> next cycle:
//    - IDLE, req=0, busy=0;
//    - no round_done pulse;
//    - timeout_flags hold partial results.
//  frame_tick in the same cycle NEXT->IDLE completes: not accepted (busy), overrun=1.
//  Reset mid-round overrides everything (req drops on the next edge).
//  Counter widths: cnt sized clog2(max(REQ_LEN,TIMEOUT)+1); no wrap inside a state.
// TESTING (NCH=4, REQ_LEN=5, TIMEOUT=16)
//  Reset: hold nRST=0 3 cycles with frame_tick=1 -> all outputs 0, no req.
//  All respond: rise on each ch 3 cycles into WAIT ->
//    - req[0..3] each 5 cycles in order;
//    - round_done once;
//    - timeout_flags=0000;
//    - round length 4*(5+3+1)=36 cycles.
//  Ch2 silent -> timeout_flags=0100; ch2 WAIT lasts 16 cycles; ch3 still polled.
//  frame_tick again while busy -> overrun 1 cycle; round length unchanged; no second round.
//  en dropped during ch1 REQ -> req=0 and busy=0 next cycle; no round_done.
//  Early response: rise[ch] during REQ -> WAIT lasts 1 cycle.
//  rx_done held high from before round (no edge) -> channel times out.

Source files
------------

// File: rtl/rx_poll_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : rx_poll_scheduler
//  Description : Round-robin poll sequencer for NCH receive channels that
//                share one request/response protocol. Each accepted
//                frame_tick starts a round that walks channels 0..NCH-1:
//                a fixed-length req pulse, then a bounded wait for the
//                channel's rx_done rising edge, then on to the next channel.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   system clock, all logic on posedge
//    nRST           in   synchronous reset, active-low
//    en             in   scheduler enable; low forces IDLE
//    frame_tick     in   1-cycle pulse that starts a poll round
//    rx_done        in   per-channel receive-complete level
//    req            out  one-hot registered request to the current channel
//    cur_ch         out  channel currently being served
//    busy           out  high while a round is in progress
//    round_done     out  1-cycle pulse after the last channel finishes
//    timeout_flags  out  bit i set if channel i timed out this/last round
//    overrun        out  1-cycle pulse: frame_tick seen while busy (ignored)
// ============================================================================
module rx_poll_scheduler #(
  parameter int NCH     = 4,
  parameter int REQ_LEN = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   nRST,
  input  logic                   en,
  input  logic                   frame_tick,
  input  logic [NCH-1:0]         rx_done,
  output logic [NCH-1:0]         req,
  output logic [$clog2(NCH)-1:0] cur_ch,
  output logic                   busy,
  output logic                   round_done,
  output logic [NCH-1:0]         timeout_flags,
  output logic                   overrun
);

  localparam int CH_W    = $clog2(NCH);
  localparam int CNT_MAX = (REQ_LEN > TIMEOUT) ? REQ_LEN : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] NEXT = 2'd3;

  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NCH - 1);
  localparam logic [CNT_W-1:0] REQ_LAST = CNT_W'(REQ_LEN - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state;
  logic [CH_W-1:0]  ch;
  logic [CNT_W-1:0] cnt;
  logic             got;     // current channel already answered during REQ
  logic [NCH-1:0]   rx_d;
  logic [NCH-1:0]   rise;
  logic             cur_rise;

  assign rise     = rx_done & ~rx_d;
  assign cur_rise = rise[ch];
  assign busy     = (state != IDLE);
  assign cur_ch   = ch;

  function automatic logic [NCH-1:0] onehot(input logic [CH_W-1:0] c);
    logic [NCH-1:0] v;
    v = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (!nRST) begin
      state         <= IDLE;
      ch            <= '0;
      cnt           <= '0;
      got           <= 1'b0;
      rx_d          <= '0;
      req           <= '0;
      round_done    <= 1'b0;
      timeout_flags <= '0;
      overrun       <= 1'b0;
    end else begin
      rx_d       <= rx_done;
      round_done <= 1'b0;
      // A tick while a round runs (including the final NEXT cycle) is dropped
      // and flagged; with en low the tick is simply ignored.
      overrun    <= en & frame_tick & (state != IDLE);

      if (!en) begin
        // Abort: partial timeout_flags and ch are kept for inspection.
        state <= IDLE;
        req   <= '0;
        got   <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (frame_tick) begin
              state         <= REQ;
              ch            <= '0;
              cnt           <= '0;
              got           <= 1'b0;
              timeout_flags <= '0;
              req           <= onehot('0);
            end
          end

          REQ: begin
            if (cur_rise) got <= 1'b1;
            if (cnt == REQ_LAST) begin
              state <= WAIT;
              cnt   <= '0;
              req   <= '0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          WAIT: begin
            if (got || cur_rise) begin
              state <= NEXT;
            end else if (cnt == TO_LAST) begin
              timeout_flags[ch] <= 1'b1;
              state             <= NEXT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          NEXT: begin
            got <= 1'b0;
            if (ch == LAST_CH) begin
              // ch deliberately stays on the last channel until the next round.
              round_done <= 1'b1;
              state      <= IDLE;
            end else begin
              ch    <= ch + CH_W'(1);
              cnt   <= '0;
              req   <= onehot(ch + CH_W'(1));
              state <= REQ;
            end
          end

          default: begin
            state <= IDLE;
            req   <= '0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rx_poll_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rx_poll_scheduler
//  Description : Directed self-checking bench for rx_poll_scheduler
//                (NCH=4, REQ_LEN=5, TIMEOUT=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rx_poll_scheduler;

  localparam int NCH = 4;

  logic           clk = 1'b0;
  logic           nRST = 1'b0;
  logic           en = 1'b0;
  logic           frame_tick = 1'b0;
  logic [NCH-1:0] rx_done = '0;
  logic [NCH-1:0] req;
  logic [1:0]     cur_ch;
  logic           busy;
  logic           round_done;
  logic [NCH-1:0] timeout_flags;
  logic           overrun;

  rx_poll_scheduler #(.NCH(4), .REQ_LEN(5), .TIMEOUT(16)) dut (
    .clk(clk), .nRST(nRST), .en(en), .frame_tick(frame_tick),
    .rx_done(rx_done), .req(req), .cur_ch(cur_ch), .busy(busy),
    .round_done(round_done), .timeout_flags(timeout_flags), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- receiver model ----------------
  // mode: -1 silent, 0 answer in 3rd REQ cycle, k>0 answer in k-th WAIT cycle
  int             mode [NCH];
  logic [NCH-1:0] hold = '0;
  logic [NCH-1:0] resp = '0;
  logic [NCH-1:0] prev_req = '0;
  int             rcnt [NCH];
  int             wcnt [NCH];

  initial for (int i = 0; i < NCH; i++) begin
    mode[i] = 3; rcnt[i] = 0; wcnt[i] = 0;
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (req[i] && !prev_req[i]) begin
        rcnt[i] = 1; wcnt[i] = 0; resp[i] = 1'b0;
      end else if (req[i]) begin
        rcnt[i]++;
      end
      if (!req[i] && prev_req[i] && busy) wcnt[i] = 1;
      else if (wcnt[i] != 0) wcnt[i]++;
      if (!busy || cur_ch != 2'(i)) wcnt[i] = 0;
      if (mode[i] == 0 && req[i] && rcnt[i] == 3) resp[i] = 1'b1;
      if (mode[i] > 0 && wcnt[i] == mode[i]) resp[i] = 1'b1;
    end
    prev_req = req;
    rx_done  = resp | hold;
  end

  // ---------------- activity monitor ----------------
  int busy_tot = 0, rd_tot = 0, ov_tot = 0, multi_tot = 0;
  int req_tot [NCH];
  int span_tot [NCH];
  int order_q [$];
  logic [NCH-1:0] mprev = '0;

  initial for (int i = 0; i < NCH; i++) begin
    req_tot[i] = 0; span_tot[i] = 0;
  end

  always @(negedge clk) begin
    busy_tot += int'(busy);
    rd_tot   += int'(round_done);
    ov_tot   += int'(overrun);
    if ($countones(req) > 1) multi_tot++;
    for (int i = 0; i < NCH; i++) begin
      req_tot[i] += int'(req[i]);
      if (busy && cur_ch == 2'(i)) span_tot[i]++;
      if (req[i] && !mprev[i]) order_q.push_back(i);
    end
    mprev = req;
  end

  int s_busy, s_rd, s_ov, s_ord;
  int s_req [NCH];
  int s_span [NCH];

  task automatic snap();
    s_busy = busy_tot; s_rd = rd_tot; s_ov = ov_tot; s_ord = order_q.size();
    for (int i = 0; i < NCH; i++) begin
      s_req[i] = req_tot[i]; s_span[i] = span_tot[i];
    end
  endtask

  task automatic start_round();
    snap();
    @(posedge clk); #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge clk); n++;
    end while (!round_done && n < 300);
    check({tag, "_round_end"}, int'(round_done), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_round(input string tag, input int exp_busy,
                             input int sp0, input int sp1, input int sp2, input int sp3,
                             input int exp_flags, input int exp_ov);
    check({tag, "_busy_len"}, busy_tot - s_busy, exp_busy);
    check({tag, "_span0"}, span_tot[0] - s_span[0], sp0);
    check({tag, "_span1"}, span_tot[1] - s_span[1], sp1);
    check({tag, "_span2"}, span_tot[2] - s_span[2], sp2);
    check({tag, "_span3"}, span_tot[3] - s_span[3], sp3);
    check({tag, "_flags"}, int'(timeout_flags), exp_flags);
    check({tag, "_round_done_cnt"}, rd_tot - s_rd, 1);
    check({tag, "_overrun_cnt"}, ov_tot - s_ov, exp_ov);
  endtask

  initial begin
    // ---- reset with tick asserted ----
    nRST = 1'b0; en = 1'b1; frame_tick = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req", int'(req), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_cur_ch", int'(cur_ch), 0);
    check("rst_round_done", int'(round_done), 0);
    check("rst_flags", int'(timeout_flags), 0);
    check("rst_overrun", int'(overrun), 0);
    @(posedge clk); #1 nRST = 1'b1; frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // ---- all channels respond 3 cycles into WAIT ----
    start_round();
    @(negedge clk);
    check("A_first_req", int'(req), 1);
    wait_done("A");
    check_round("A", 36, 9, 9, 9, 9, 0, 0);
    for (int i = 0; i < NCH; i++) check($sformatf("A_req_len%0d", i), req_tot[i] - s_req[i], 5);
    check("A_order_n", order_q.size() - s_ord, 4);
    for (int k = 0; k < 4; k++) check($sformatf("A_order%0d", k), order_q[s_ord + k], k);
    check("A_cur_ch_end", int'(cur_ch), 3);

    // ---- channel 2 silent ----
    mode[2] = -1;
    start_round();
    wait_done("B");
    check_round("B", 49, 9, 9, 22, 9, 4, 0);
    mode[2] = 3;

    // ---- tick while busy ----
    start_round();
    repeat (9) @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk); #1 frame_tick = 1'b0;
    @(negedge clk);
    check("C_overrun_pulse", int'(overrun), 1);
    wait_done("C");
    check_round("C", 36, 9, 9, 9, 9, 0, 1);
    repeat (10) @(posedge clk);
    check("C_no_second_round", busy_tot - s_busy, 36);

    // ---- early response on ch1 ----
    mode[1] = 0;
    start_round();
    wait_done("E");
    check_round("E", 34, 9, 7, 9, 9, 0, 0);
    mode[1] = 3;

    // ---- rx_done held high before round on ch3 ----
    hold[3] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_round();
    wait_done("F");
    check_round("F", 49, 9, 9, 9, 22, 8, 0);
    hold[3] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // ---- tick in the final NEXT cycle ----
    start_round();
    repeat (35) @(posedge clk);
    #1 frame_tick = 1'b1;
    @(negedge clk);
    check("G_busy_in_last_next", int'(busy), 1);
    @(posedge clk); #1 frame_tick = 1'b0;
    @(negedge clk);
    check("G_overrun", int'(overrun), 1);
    check("G_round_done", int'(round_done), 1);
    check("G_busy_after", int'(busy), 0);
    repeat (5) @(posedge clk);
    check("G_busy_len", busy_tot - s_busy, 36);
    check("G_rd_cnt", rd_tot - s_rd, 1);

    // ---- tick with en low ----
    #1 en = 1'b0;
    start_round();
    repeat (5) @(posedge clk);
    check("H_busy_len", busy_tot - s_busy, 0);
    check("H_overrun_cnt", ov_tot - s_ov, 0);
    #1 en = 1'b1;

    // ---- en dropped during ch1 REQ (ch0 silent) ----
    mode[0] = -1;
    start_round();
    begin
      int n = 0;
      while (!req[1] && n < 100) begin
        @(posedge clk); #1; n++;
      end
      check("D_reached_ch1", int'(req[1]), 1);
    end
    @(posedge clk); #1 en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("D_req_off", int'(req), 0);
    check("D_busy_off", int'(busy), 0);
    repeat (5) @(posedge clk);
    check("D_req1_len", req_tot[1] - s_req[1], 2);
    check("D_no_round_done", rd_tot - s_rd, 0);
    check("D_flags_partial", int'(timeout_flags), 1);
    check("D_no_overrun", ov_tot - s_ov, 0);
    #1 en = 1'b1; mode[0] = 3;

    // ---- reset mid-round ----
    start_round();
    repeat (3) @(posedge clk);
    #1 nRST = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("R_req", int'(req), 0);
    check("R_busy", int'(busy), 0);
    check("R_flags", int'(timeout_flags), 0);
    @(posedge clk); #1 nRST = 1'b1;
    repeat (3) @(posedge clk);

    check("onehot_violations", multi_tot, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
